gnr_attractor_ctrl: RTL and testbench

Sweep controller for the Boolean gene-regulatory-network datapath. It enumerates every initial network state and drives the per-node load/step strobes of the dual-copy node registers (s0 tortoise, s1 hare). It watches the gathered s0/s1 state vectors to detect an attractor with Floyd cycle detection, then measures the attractor period. Each result is emitted as one record on a valid/ready output channel toward the result writer.

---
 rtl/gnr_attractor_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_gnr_attractor_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gnr_attractor_ctrl.sv
// Sweep controller for the Boolean gene-regulatory-network datapath.
// Walks every initial state, drives the tortoise/hare node strobes and runs
// Floyd cycle detection followed by a period measurement. One result record
// per initial state leaves on a valid/ready channel.
module gnr_attractor_ctrl #(
    parameter int N_NODES   = 8,
    parameter int MAX_STEPS = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [N_NODES-1:0] state_s0,
    input  logic [N_NODES-1:0] state_s1,
    output logic               reset_nos,
    output logic               start_s0,
    output logic               start_s1,
    output logic [N_NODES-1:0] init_state,
    output logic               busy,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N_NODES-1:0] out_init,
    output logic [N_NODES-1:0] out_attractor,
    output logic [15:0]        out_meet,
    output logic [15:0]        out_period,
    output logic               out_timeout,
    output logic               done
);

    localparam logic [15:0]        MAX_MEET  = 16'(MAX_STEPS);
    localparam logic [15:0]        CNT_MAX   = 16'hFFFF;
    localparam logic [N_NODES-1:0] LAST_INIT = '1;

    typedef enum logic [2:0] {
        IDLE, LOAD, PRIME, CHECK, STEP, PSTEP, PCHECK, OUT
    } state_e;

    state_e             state_q, state_d;
    logic [N_NODES-1:0] cur_q, cur_d;
    logic [N_NODES-1:0] init_state_q, init_state_d;
    logic [N_NODES-1:0] attr_q, attr_d;
    logic [15:0]        meet_q, meet_d;
    logic [15:0]        period_q, period_d;
    logic               timeout_q, timeout_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               reset_nos_q, reset_nos_d;
    logic               start_s0_q, start_s0_d;
    logic               start_s1_q, start_s1_d;
    logic               out_valid_q, out_valid_d;
    logic               vec_equal;

    // Counters stick at their maximum instead of wrapping.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == CNT_MAX) ? v : v + 16'd1;
    endfunction

    assign vec_equal = (state_s0 == state_s1);

    // Next-state, counter and record logic; strobes decode the next state so
    // they are registered and line up with the state they belong to.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned, which would otherwise infer a latch.
        state_d   = state_q;
        cur_d     = cur_q;
        attr_d    = attr_q;
        meet_d    = meet_q;
        period_d  = period_q;
        timeout_d = timeout_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    cur_d   = '0;
                    busy_d  = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                meet_d    = '0;
                period_d  = '0;
                timeout_d = 1'b0;
                attr_d    = '0;
                state_d   = PRIME;
            end
            PRIME: begin
                // Hare gets one step head start so the first compare is f(x) vs x.
                meet_d  = 16'd1;
                state_d = CHECK;
            end
            CHECK: begin
                if (vec_equal) begin
                    attr_d  = state_s1;
                    state_d = PSTEP;
                end else if (meet_q >= MAX_MEET) begin
                    timeout_d = 1'b1;
                    period_d  = '0;
                    state_d   = OUT;
                end else begin
                    state_d = STEP;
                end
            end
            STEP: begin
                meet_d  = sat_inc(meet_q);
                state_d = CHECK;
            end
            PSTEP: begin
                // Tortoise is frozen on the cycle; count hare steps back to it.
                period_d = sat_inc(period_q);
                state_d  = PCHECK;
            end
            PCHECK: begin
                if (vec_equal) begin
                    state_d = OUT;
                end else if (period_q == CNT_MAX) begin
                    timeout_d = 1'b1;
                    period_d  = '0;
                    state_d   = OUT;
                end else begin
                    state_d = PSTEP;
                end
            end
            OUT: begin
                if (out_ready) begin
                    if (cur_q == LAST_INIT) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        cur_d   = cur_q + 1'b1;
                        state_d = LOAD;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        reset_nos_d  = (state_d == LOAD);
        start_s0_d   = (state_d == STEP);
        start_s1_d   = (state_d == PRIME) || (state_d == STEP) || (state_d == PSTEP);
        out_valid_d  = (state_d == OUT);
        init_state_d = (state_d == IDLE) ? '0 : cur_d;
    end

    // State register: synchronous reset aborts any sweep in progress.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            state_q      <= IDLE;
            cur_q        <= '0;
            init_state_q <= '0;
            attr_q       <= '0;
            meet_q       <= '0;
            period_q     <= '0;
            timeout_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            reset_nos_q  <= 1'b0;
            start_s0_q   <= 1'b0;
            start_s1_q   <= 1'b0;
            out_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_q        <= cur_d;
            init_state_q <= init_state_d;
            attr_q       <= attr_d;
            meet_q       <= meet_d;
            period_q     <= period_d;
            timeout_q    <= timeout_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            reset_nos_q  <= reset_nos_d;
            start_s0_q   <= start_s0_d;
            start_s1_q   <= start_s1_d;
            out_valid_q  <= out_valid_d;
        end
    end

    assign reset_nos     = reset_nos_q;
    assign start_s0      = start_s0_q;
    assign start_s1      = start_s1_q;
    assign init_state    = init_state_q;
    assign busy          = busy_q;
    assign out_valid     = out_valid_q;
    assign out_init      = cur_q;
    assign out_attractor = attr_q;
    assign out_meet      = meet_q;
    assign out_period    = period_q;
    assign out_timeout   = timeout_q;
    assign done          = done_q;

endmodule

// File: tb/tb_gnr_attractor_ctrl.sv
// Directed bench for gnr_attractor_ctrl with N_NODES=4. A behavioural node
// model closes the loop: hare advances on every start_s1, tortoise on every
// second start_s0 after a load. Two instances: default step limit and limit 3.
module tb_gnr_attractor_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    logic start_m = 1'b0, start_t = 1'b0;
    logic ready = 1'b0;
    int   mode = 0;     // 0: f=x, 1: f=x+1 mod 16, 2: f=x>>1
    logic sel = 1'b0;   // 0: main instance, 1: step-limit-3 instance

    // main instance
    logic       reset_nos, start_s0, start_s1, busy, out_valid, out_timeout, done;
    logic [3:0] init_state, out_init, out_attractor;
    logic [15:0] out_meet, out_period;
    logic [3:0] s0 = '0, s1 = '0;
    logic       pass = 1'b1;

    // step-limited instance
    logic       t_reset_nos, t_start_s0, t_start_s1, t_busy, t_out_valid, t_out_timeout, t_done;
    logic [3:0] t_init_state, t_out_init, t_out_attractor;
    logic [15:0] t_out_meet, t_out_period;
    logic [3:0] t_s0 = '0, t_s1 = '0;
    logic       t_pass = 1'b1;

    gnr_attractor_ctrl #(.N_NODES(4)) dut (
        .clk(clk), .rst(rst), .start(start_m), .state_s0(s0), .state_s1(s1),
        .reset_nos(reset_nos), .start_s0(start_s0), .start_s1(start_s1),
        .init_state(init_state), .busy(busy), .out_valid(out_valid), .out_ready(ready),
        .out_init(out_init), .out_attractor(out_attractor), .out_meet(out_meet),
        .out_period(out_period), .out_timeout(out_timeout), .done(done)
    );

    gnr_attractor_ctrl #(.N_NODES(4), .MAX_STEPS(3)) dut_t (
        .clk(clk), .rst(rst), .start(start_t), .state_s0(t_s0), .state_s1(t_s1),
        .reset_nos(t_reset_nos), .start_s0(t_start_s0), .start_s1(t_start_s1),
        .init_state(t_init_state), .busy(t_busy), .out_valid(t_out_valid), .out_ready(ready),
        .out_init(t_out_init), .out_attractor(t_out_attractor), .out_meet(t_out_meet),
        .out_period(t_out_period), .out_timeout(t_out_timeout), .done(t_done)
    );

    function automatic logic [3:0] nf(input int m, input logic [3:0] x);
        case (m)
            0:       return x;
            1:       return x + 4'd1;
            default: return x >> 1;
        endcase
    endfunction

    // node register models
    always @(posedge clk) begin
        if (reset_nos) begin
            s0 <= init_state; s1 <= init_state; pass <= 1'b1;
        end else begin
            if (start_s1) s1 <= nf(mode, s1);
            if (start_s0) begin
                if (!pass) s0 <= nf(mode, s0);
                pass <= ~pass;
            end
        end
    end

    always @(posedge clk) begin
        if (t_reset_nos) begin
            t_s0 <= t_init_state; t_s1 <= t_init_state; t_pass <= 1'b1;
        end else begin
            if (t_start_s1) t_s1 <= nf(mode, t_s1);
            if (t_start_s0) begin
                if (!t_pass) t_s0 <= nf(mode, t_s0);
                t_pass <= ~t_pass;
            end
        end
    end

    // record view of whichever instance is under test
    logic        rec_valid, rec_to, rec_done, rec_busy;
    logic [3:0]  rec_init, rec_attr;
    logic [15:0] rec_meet, rec_period;
    assign rec_valid  = sel ? t_out_valid   : out_valid;
    assign rec_to     = sel ? t_out_timeout : out_timeout;
    assign rec_done   = sel ? t_done        : done;
    assign rec_busy   = sel ? t_busy        : busy;
    assign rec_init   = sel ? t_out_init    : out_init;
    assign rec_attr   = sel ? t_out_attractor : out_attractor;
    assign rec_meet   = sel ? t_out_meet    : out_meet;
    assign rec_period = sel ? t_out_period  : out_period;

    // hand-derived meeting counts for f=x>>1: 2*bitlen(x)+1
    int shr_meet [16] = '{1, 3, 5, 5, 7, 7, 7, 7, 9, 9, 9, 9, 9, 9, 9, 9};

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_rec(input int idx);
        logic [3:0] ii;
        ii = 4'(idx);
        check($sformatf("init[%0d]", idx), 32'(rec_init), 32'(ii));
        if (sel) begin
            check($sformatf("lim_timeout[%0d]", idx), 32'(rec_to), 32'd1);
            check($sformatf("lim_period[%0d]", idx), 32'(rec_period), 32'd0);
            check($sformatf("lim_meet[%0d]", idx), 32'(rec_meet), 32'd3);
        end else begin
            check($sformatf("timeout[%0d]", idx), 32'(rec_to), 32'd0);
            case (mode)
                0: begin
                    check($sformatf("id_attr[%0d]", idx), 32'(rec_attr), 32'(ii));
                    check($sformatf("id_meet[%0d]", idx), 32'(rec_meet), 32'd1);
                    check($sformatf("id_period[%0d]", idx), 32'(rec_period), 32'd1);
                end
                1: begin
                    check($sformatf("inc_attr[%0d]", idx), 32'(rec_attr), 32'(4'(ii + 4'd14)));
                    check($sformatf("inc_meet[%0d]", idx), 32'(rec_meet), 32'd30);
                    check($sformatf("inc_period[%0d]", idx), 32'(rec_period), 32'd16);
                end
                default: begin
                    check($sformatf("shr_attr[%0d]", idx), 32'(rec_attr), 32'd0);
                    check($sformatf("shr_meet[%0d]", idx), 32'(rec_meet), 32'(shr_meet[idx]));
                    check($sformatf("shr_period[%0d]", idx), 32'(rec_period), 32'd1);
                end
            endcase
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        if (sel) start_t = 1'b1; else start_m = 1'b1;
        @(negedge clk);
        start_m = 1'b0; start_t = 1'b0;
    endtask

    // Accept records from index 'first' on; optionally pokes start at cycle 'poke'.
    task automatic collect(input int first, input int poke);
        int rec;
        int budget;
        rec = first; budget = 0;
        forever begin
            start_m = (poke != 0 && budget == poke);
            if (rec_valid && ready) begin
                check_rec(rec);
                rec++;
            end
            if (rec == 16 || budget >= 20000) break;
            @(negedge clk);
            budget++;
        end
        start_m = 1'b0;
        check("record_count", 32'(rec), 32'd16);
        @(negedge clk);
        check("done_pulse", 32'(rec_done), 32'd1);
        check("busy_fall", 32'(rec_busy), 32'd0);
        @(negedge clk);
        check("done_one_cycle", 32'(rec_done), 32'd0);
    endtask

    initial begin
        int cnt;
        logic stable, seen;
        logic [3:0] snap_init, snap_attr;
        logic [15:0] snap_meet, snap_period;
        logic snap_to;

        // reset overrides a simultaneous start
        start_m = 1'b1;
        repeat (2) @(negedge clk);
        start_m = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_strobes", 32'({reset_nos, start_s0, start_s1}), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_init_state", 32'(init_state), 32'd0);
        check("rst_fields", 32'({out_init, out_attractor, out_timeout}), 32'd0);
        check("rst_counts", {out_meet, out_period}, 32'd0);
        rst = 1'b0;

        // f=x, first record stalled
        mode = 0; sel = 1'b0; ready = 1'b0;
        @(negedge clk);
        start_m = 1'b1;
        @(negedge clk);
        start_m = 1'b0;
        cnt = 1;
        check("load_strobe", 32'(reset_nos), 32'd1);
        check("busy_rise", 32'(busy), 32'd1);
        while (!out_valid && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        check("fixed_point_latency", 32'(cnt), 32'd6);
        snap_init = out_init; snap_attr = out_attractor; snap_meet = out_meet;
        snap_period = out_period; snap_to = out_timeout;
        stable = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (!out_valid || reset_nos || start_s0 || start_s1 ||
                out_init != snap_init || out_attractor != snap_attr ||
                out_meet != snap_meet || out_period != snap_period || out_timeout != snap_to)
                stable = 1'b0;
        end
        check("stall_stable", 32'(stable), 32'd1);
        ready = 1'b1;
        check_rec(0);
        @(negedge clk);
        check("b2b_load", 32'(reset_nos), 32'd1);
        check("b2b_valid_low", 32'(out_valid), 32'd0);
        check("b2b_init_state", 32'(init_state), 32'd1);
        collect(1, 0);

        // f=x+1, with a start poke mid-sweep that must be ignored
        mode = 1;
        pulse_start();
        collect(0, 300);

        // f=x>>1, aborted by reset during a STEP of record 5
        mode = 2;
        pulse_start();
        cnt = 0;
        while (!(init_state == 4'd5 && start_s0) && cnt < 2000) begin
            @(negedge clk);
            cnt++;
        end
        check("reach_step_rec5", 32'(init_state == 4'd5 && start_s0), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_outputs", 32'({busy, out_valid, done, reset_nos, start_s0, start_s1, out_timeout}), 32'd0);
        check("abort_fields", 32'({init_state, out_init, out_attractor}), 32'd0);
        check("abort_counts", {out_meet, out_period}, 32'd0);
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (done || out_valid || busy) seen = 1'b1;
        end
        check("no_done_after_abort", 32'(seen), 32'd0);
        pulse_start();
        collect(0, 0);

        // step limit 3 with f=x+1
        mode = 1; sel = 1'b1;
        pulse_start();
        collect(0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
